// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 types, constants and byte-level helper functions.
// Contents: aes_block_t, the controller FSM encoding, the round-constant
// table, the S-box and the SubBytes/ShiftRows/SubWord/RotWord transforms.
// Bytes are in FIPS-197 order: byte 0 sits in [127:120], and the state
// element at row r, column c is byte r+4c.
package aes_round_ctrl_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rounds outside 1..10 never consume a key step, so they map to zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) begin
            return RCON[r];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box built from its definition: multiplicative inverse in GF(2^8)
    // (as b^254, which also maps 0 to 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] pw;
        inv = 8'h01;
        pw  = b;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) begin
                inv = gf_mul(inv, pw);
            end
            pw = gf_mul(pw, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic aes_block_t sub_bytes(input aes_block_t s);
        aes_block_t o;
        for (int i = 0; i < 16; i++) begin
            o[i*8 +: 8] = sbox(s[i*8 +: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
    function automatic aes_block_t shift_rows(input aes_block_t s);
        aes_block_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake bundle for the AES round controller.
// Input side:  in_valid/in_ready with in_key and in_data (plaintext).
// Output side: out_valid/out_ready with out_data (ciphertext).
// slave  = the controller's view, master = the producer/consumer's view.
interface aes_round_ctrl_if;
    import aes_round_ctrl_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_block_t in_key;
    aes_block_t in_data;
    logic       out_valid;
    logic       out_ready;
    aes_block_t out_data;

    modport slave (
        input  in_valid, in_key, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_key, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_round_ctrl_key_step.sv
// One AES-128 key-schedule step: next round key from the current one.
// Ports: key (current round key, word 0 in [127:96]), rcon (round
// constant), key_next (following round key).
module aes_round_ctrl_key_step
    import aes_round_ctrl_pkg::*;
(
    input  aes_block_t key,
    input  logic [7:0] rcon,
    output aes_block_t key_next
);

    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        t  = sub_word(rot_word(key[31:0])) ^ {rcon, 24'h000000};
        n0 = key[127:96] ^ t;
        n1 = key[95:64]  ^ n0;
        n2 = key[63:32]  ^ n1;
        n3 = key[31:0]   ^ n2;
        key_next = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/mix_columns.sv
// Combinational AES MixColumns over a full 128-bit state.
// Ports: state_in (column 0 in [127:96]), state_out (same layout).
module mix_columns
    import aes_round_ctrl_pkg::*;
(
    input  aes_block_t state_in,
    output aes_block_t state_out
);

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        state_out = '0;
        for (int c = 0; c < 4; c++) begin
            state_out[127 - 32*c -: 32] = mix_column(state_in[127 - 32*c -: 32]);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer, one block in flight.
// Accepts a key/plaintext pair, performs the initial AddRoundKey on the
// accept edge, then UNROLL rounds per clock with the key schedule expanded
// on the fly, and presents the ciphertext until the consumer takes it.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - handshake bundle (slave side): in_valid/in_ready/in_key/in_data,
//            out_valid/out_ready/out_data
//   busy   - high while rounds are being computed
module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_round_ctrl_if.slave   bus,
    output logic              busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5)) begin : g_bad_unroll
        $error("aes_round_ctrl: UNROLL must be 1, 2 or 5");
    end

    fsm_t       fsm_q, fsm_nxt;
    aes_block_t state_q, rkey_q, out_data_q;
    logic [3:0] rnd_q;
    aes_block_t s_final, k_final;
    logic       load, step, last;

    // Each slot is one round; slot i handles round rnd_q+i and feeds slot i+1.
    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        aes_block_t s_in, k_in, s_out, k_out, sr, mc;
        logic [3:0] rnd_slot;

        if (i == 0) begin : g_first
            assign s_in = state_q;
            assign k_in = rkey_q;
        end else begin : g_chain
            assign s_in = g_round[i-1].s_out;
            assign k_in = g_round[i-1].k_out;
        end

        assign rnd_slot = rnd_q + 4'(i);
        assign sr       = shift_rows(sub_bytes(s_in));

        aes_round_ctrl_key_step u_key_step (
            .key      (k_in),
            .rcon     (rcon_of(rnd_slot)),
            .key_next (k_out)
        );

        mix_columns u_mix_columns (
            .state_in  (sr),
            .state_out (mc)
        );

        // The final round skips MixColumns.
        assign s_out = ((rnd_slot == 4'd10) ? sr : mc) ^ k_out;
    end

    assign s_final = g_round[UNROLL-1].s_out;
    assign k_final = g_round[UNROLL-1].k_out;
    assign last    = (rnd_q == 4'(11 - UNROLL));

    assign bus.out_data = out_data_q;

    always_comb begin
        fsm_nxt       = fsm_q;
        load          = 1'b0;
        step          = 1'b0;
        busy          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    fsm_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    fsm_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                // A new pair may be taken in the same cycle the result leaves.
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        load    = 1'b1;
                        fsm_nxt = ST_RUN;
                    end else begin
                        fsm_nxt = ST_IDLE;
                    end
                end
            end
            default: fsm_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= ST_IDLE;
            state_q    <= '0;
            rkey_q     <= '0;
            rnd_q      <= '0;
            out_data_q <= '0;
        end else begin
            fsm_q <= fsm_nxt;
            if (load) begin
                state_q <= bus.in_data ^ bus.in_key;
                rkey_q  <= bus.in_key;
                rnd_q   <= 4'd1;
            end else if (step) begin
                state_q <= s_final;
                rkey_q  <= k_final;
                // Hold on the final cycle so rnd stays within 1..10.
                if (!last) begin
                    rnd_q <= rnd_q + 4'(UNROLL);
                end
            end
            if (step && last) begin
                out_data_q <= s_final;
            end
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: FIPS-197 vectors through a scoreboard on the
// UNROLL=1 instance, plus UNROLL=2 and UNROLL=5 instances for latency.
module tb_aes_round_ctrl;
    import aes_round_ctrl_pkg::*;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, busy2, busy5;

    always #5 clk = ~clk;

    aes_round_ctrl_if bus();
    aes_round_ctrl_if bus2();
    aes_round_ctrl_if bus5();

    aes_round_ctrl #(.UNROLL(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
    aes_round_ctrl #(.UNROLL(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2));
    aes_round_ctrl #(.UNROLL(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5), .busy(busy5));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] expect_ct(input logic [127:0] k, input logic [127:0] p);
        if (k == K1 && p == P1) return C1;
        if (k == K2 && p == P2) return C2;
        return '1;
    endfunction

    typedef struct {
        logic [127:0] d;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   accepts = 0;
    int   xfers = 0;
    int   last_xfer = 0;
    int   xfer_gap = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, check latency on out_valid rise, pop on transfer.
    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            ov_prev = 1'b0;
        end else begin
            if (bus.out_valid && !ov_prev) begin
                if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
                else check("latency", 128'(cyc - exp_q[0].acc - 1), 10);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.d);
                end
                xfers++;
                xfer_gap  = cyc - last_xfer;
                last_xfer = cyc;
            end
            if (bus.in_valid && bus.in_ready) begin
                e.d   = expect_ct(bus.in_key, bus.in_data);
                e.acc = cyc;
                exp_q.push_back(e);
                accepts++;
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic send(input logic [127:0] k, input logic [127:0] p);
        bit done;
        done = 0;
        bus.in_key   = k;
        bus.in_data  = p;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("send_accepted", 128'(done), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 128'(exp_q.size()), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, x0, lat2, lat5;
        bus.in_valid = 0;  bus.in_key = '0;  bus.in_data = '0;  bus.out_ready = 0;
        bus2.in_valid = 0; bus2.in_key = '0; bus2.in_data = '0; bus2.out_ready = 0;
        bus5.in_valid = 0; bus5.in_key = '0; bus5.in_data = '0; bus5.out_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // UNROLL=2 and UNROLL=5 on vector 2
        check("u2_in_ready", bus2.in_ready, 1);
        check("u5_in_ready", bus5.in_ready, 1);
        bus2.in_key = K2; bus2.in_data = P2; bus2.in_valid = 1;
        bus5.in_key = K2; bus5.in_data = P2; bus5.in_valid = 1;
        @(posedge clk);
        #1;
        bus2.in_valid = 0; bus5.in_valid = 0;
        lat2 = -1; lat5 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus2.out_valid && lat2 < 0) lat2 = i;
            if (bus5.out_valid && lat5 < 0) lat5 = i;
        end
        check("u2_latency", 128'(lat2), 5);
        check("u5_latency", 128'(lat5), 2);
        check("u2_out_data", bus2.out_data, C2);
        check("u5_out_data", bus5.out_data, C2);

        // Vectors 1 and 2, out_ready high
        bus.out_ready = 1;
        send(K1, P1);
        drain();
        send(K2, P2);
        drain();

        // Inputs change right after acceptance
        send(K1, P1);
        bus.in_key  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        drain();

        // Backpressure
        bus.out_ready = 0;
        send(K1, P1);
        for (int i = 0; i < 30 && !bus.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("bp_out_valid", bus.out_valid, 1);
        bus.in_key = K2; bus.in_data = P2; bus.in_valid = 1;
        a0 = accepts;
        x0 = xfers;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold_data", bus.out_data, C1);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        check("bp_no_accept", 128'(accepts), 128'(a0));
        @(posedge clk);
        #1;
        bus.in_valid  = 0;
        bus.out_ready = 1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("bp_one_transfer", 128'(xfers), 128'(x0 + 1));
        check("bp_idle_after", bus.out_valid, 0);

        // Back-to-back with in_valid held
        a0 = accepts;
        bus.in_key = K1; bus.in_data = P1; bus.in_valid = 1;
        for (int i = 0; i < 60 && accepts < a0 + 2; i++) begin
            @(posedge clk);
            #1;
            if (accepts == a0 + 1) begin
                bus.in_key = K2; bus.in_data = P2;
            end
        end
        bus.in_valid = 0;
        check("b2b_accepts", 128'(accepts), 128'(a0 + 2));
        drain();
        check("b2b_spacing", 128'(xfer_gap), 11);

        // Reset in the middle of RUN
        send(K1, P1);
        repeat (4) @(posedge clk);
        #2;
        check("mid_run_busy", busy, 1);
        rst_n = 0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_out_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        check("post_rst_in_ready", bus.in_ready, 1);
        send(K1, P1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
